// File: rtl/gigex_tx_sched_if.sv
// Source-FIFO and GigEx Tx port bundle for gigex_tx_sched.
// master = scheduler side, slave = sources plus GigEx side.
interface gigex_tx_sched_if;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       data_read;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       cmd_read;
  logic [7:0] info_byte;
  logic       info_valid;
  logic       info_read;
  logic [7:0] nTF;
  logic [7:0] D;
  logic [2:0] TC;
  logic       nTx;

  modport master (
    input  data_byte, data_valid, cmd_byte, cmd_valid, info_byte, info_valid, nTF,
    output data_read, cmd_read, info_read, D, TC, nTx
  );

  modport slave (
    output data_byte, data_valid, cmd_byte, cmd_valid, info_byte, info_valid, nTF,
    input  data_read, cmd_read, info_read, D, TC, nTx
  );
endinterface

// File: rtl/gigex_tx_sched.sv
// Word-atomic byte scheduler sharing the GigEx Tx port between data (0), cmd (1)
// and info (2) FWFT sources, with delayed nTF flow control and a data starvation guard.
module gigex_tx_sched #(
  parameter int DATA_BYTES   = 16,
  parameter int CMD_BYTES    = 4,
  parameter int INFO_BYTES   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             eth_clk,
  input  logic             rst_n,
  gigex_tx_sched_if.master bus,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] data_words,
  output logic [CNT_W-1:0] cmd_words,
  output logic [CNT_W-1:0] info_words,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [7:0] DATA_LAST  = 8'(DATA_BYTES - 1);
  localparam logic [7:0] CMD_LAST   = 8'(CMD_BYTES - 1);
  localparam logic [7:0] INFO_LAST  = 8'(INFO_BYTES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       starve_q, starve_d;
  logic [2:0]       ntf1_q, ntf1_d, ntf2_q, ntf2_d, ntf3_q, ntf3_d;
  logic [7:0]       d_q, d_d;
  logic [2:0]       tc_q, tc_d;
  logic             ntx_q, ntx_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d, cmd_cnt_q, cmd_cnt_d, info_cnt_q, info_cnt_d;
  logic [2:0]       valid_s, rdy_s, elig_s, rd_s, done_s;
  logic [1:0]       sel_s;
  logic             unused_s;

  function automatic logic [7:0] last_of(input logic [1:0] ch);
    case (ch)
      2'd0:    last_of = DATA_LAST;
      2'd1:    last_of = CMD_LAST;
      2'd2:    last_of = INFO_LAST;
      default: last_of = DATA_LAST;
    endcase
  endfunction

  // Only the three low nTF flags belong to our channels.
  assign unused_s = ^bus.nTF[7:3];

  assign valid_s = {bus.info_valid, bus.cmd_valid, bus.data_valid};
  // A flag low for a single cycle must not block the channel, hence the OR of two taps.
  assign rdy_s   = ntf2_q | ntf3_q;
  assign elig_s  = valid_s & rdy_s;

  always_comb begin
    ntf1_d = bus.nTF[2:0];
    ntf2_d = ntf1_q;
    ntf3_d = ntf2_q;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    rd_s     = 3'b000;
    done_s   = 3'b000;
    sel_s    = 2'd0;
    case (state_q)
      IDLE: begin
        if (|elig_s) begin
          if (elig_s[0] && (starve_q == STARVE_MAX)) begin
            sel_s = 2'd0;
          end else if (elig_s[2]) begin
            sel_s = 2'd2;
          end else if (elig_s[1]) begin
            sel_s = 2'd1;
          end else begin
            sel_s = 2'd0;
          end
          rd_s    = 3'b001 << sel_s;
          grant_d = sel_s;
          rem_d   = last_of(sel_s);
          if (sel_s == 2'd0) begin
            starve_d = 8'd0;
          end else if (elig_s[0] && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 8'd1;
          end else begin
            starve_d = starve_q;
          end
          if (last_of(sel_s) == 8'd0) begin
            done_s  = rd_s;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // rem counts bytes still owed; a stalled channel simply holds the port.
        if (elig_s[grant_q]) begin
          rd_s  = 3'b001 << grant_q;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            done_s  = rd_s;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ntx_d = ~(|rd_s);
    d_d   = d_q;
    tc_d  = tc_q;
    if (|rd_s) begin
      tc_d = {1'b0, grant_d};
      case (grant_d)
        2'd0:    d_d = bus.data_byte;
        2'd1:    d_d = bus.cmd_byte;
        2'd2:    d_d = bus.info_byte;
        default: d_d = bus.data_byte;
      endcase
    end else begin
      tc_d = tc_q;
      d_d  = d_q;
    end
    // A clear coinciding with a completion leaves the counter at zero.
    if (stats_clr) begin
      data_cnt_d = '0;
      cmd_cnt_d  = '0;
      info_cnt_d = '0;
    end else begin
      data_cnt_d = data_cnt_q + {{(CNT_W-1){1'b0}}, done_s[0]};
      cmd_cnt_d  = cmd_cnt_q  + {{(CNT_W-1){1'b0}}, done_s[1]};
      info_cnt_d = info_cnt_q + {{(CNT_W-1){1'b0}}, done_s[2]};
    end
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= 8'd0;
      grant_q    <= 2'd0;
      starve_q   <= 8'd0;
      ntf1_q     <= 3'b000;
      ntf2_q     <= 3'b000;
      ntf3_q     <= 3'b000;
      d_q        <= 8'd0;
      tc_q       <= 3'd0;
      ntx_q      <= 1'b1;
      data_cnt_q <= '0;
      cmd_cnt_q  <= '0;
      info_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      grant_q    <= grant_d;
      starve_q   <= starve_d;
      ntf1_q     <= ntf1_d;
      ntf2_q     <= ntf2_d;
      ntf3_q     <= ntf3_d;
      d_q        <= d_d;
      tc_q       <= tc_d;
      ntx_q      <= ntx_d;
      data_cnt_q <= data_cnt_d;
      cmd_cnt_q  <= cmd_cnt_d;
      info_cnt_q <= info_cnt_d;
    end
  end

  assign bus.data_read = rd_s[0];
  assign bus.cmd_read  = rd_s[1];
  assign bus.info_read = rd_s[2];
  assign bus.D         = d_q;
  assign bus.TC        = tc_q;
  assign bus.nTx       = ntx_q;
  assign data_words    = data_cnt_q;
  assign cmd_words     = cmd_cnt_q;
  assign info_words    = info_cnt_q;
  assign busy          = (state_q == SEND);

endmodule

// File: tb/tb_gigex_tx_sched.sv
// Directed bench for gigex_tx_sched: a default instance plus a CNT_W=4, DATA_BYTES=1
// instance for counter wrap; byte sources are modelled as incrementing patterns.
module tb_gigex_tx_sched;
  logic        eth_clk = 1'b0;
  logic        rst_n;
  logic        stats_clr;
  logic [31:0] data_words, cmd_words, info_words;
  logic        busy;
  logic [3:0]  s_data_words, s_cmd_words, s_info_words;
  logic        s_busy;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  d_cnt, c_cnt, i_cnt;
  logic        rd_d, rd_c, rd_i;

  gigex_tx_sched_if bus();
  gigex_tx_sched_if sbus();

  gigex_tx_sched u_dut (
    .eth_clk(eth_clk), .rst_n(rst_n), .bus(bus), .stats_clr(stats_clr),
    .data_words(data_words), .cmd_words(cmd_words), .info_words(info_words), .busy(busy)
  );

  gigex_tx_sched #(.DATA_BYTES(1), .CNT_W(4)) u_small (
    .eth_clk(eth_clk), .rst_n(rst_n), .bus(sbus), .stats_clr(stats_clr),
    .data_words(s_data_words), .cmd_words(s_cmd_words), .info_words(s_info_words), .busy(s_busy)
  );

  always #5 eth_clk = ~eth_clk;

  task automatic drive_bytes();
    bus.data_byte = d_cnt;
    bus.cmd_byte  = 8'hC0 + c_cnt;
    bus.info_byte = 8'hA0 + i_cnt;
  endtask

  task automatic set_valid(input logic d, input logic c, input logic i);
    bus.data_valid = d;
    bus.cmd_valid  = c;
    bus.info_valid = i;
  endtask

  // Samples the read strobes of the current cycle, crosses one edge, then pops sources.
  task automatic tick();
    @(negedge eth_clk);
    rd_d = bus.data_read;
    rd_c = bus.cmd_read;
    rd_i = bus.info_read;
    @(posedge eth_clk);
    #1;
    if (rd_d) d_cnt = d_cnt + 8'd1;
    if (rd_c) c_cnt = c_cnt + 8'd1;
    if (rd_i) i_cnt = i_cnt + 8'd1;
    drive_bytes();
  endtask

  task automatic apply_reset();
    @(posedge eth_clk);
    #2;
    rst_n = 1'b0;
    d_cnt = 8'd0; c_cnt = 8'd0; i_cnt = 8'd0;
    drive_bytes();
    @(posedge eth_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stats_clr = 1'b0;
    bus.nTF = 8'hFF;
    set_valid(1'b1, 1'b1, 1'b1);
    d_cnt = 8'd0; c_cnt = 8'd0; i_cnt = 8'd0;
    drive_bytes();
    sbus.data_byte = 8'h55; sbus.cmd_byte = 8'h00; sbus.info_byte = 8'h00;
    sbus.data_valid = 1'b0; sbus.cmd_valid = 1'b0; sbus.info_valid = 1'b0;
    sbus.nTF = 8'hFF;
    repeat (3) @(posedge eth_clk);
    #1;
    checks++;
    if ({bus.nTx, bus.TC, bus.D} !== {1'b1, 3'd0, 8'd0}) begin
      errors++; $display("FAIL reset_outputs: nTx/TC/D got %b/%0d/%h, expected 1/0/00", bus.nTx, bus.TC, bus.D);
    end
    checks++;
    if ({data_words, cmd_words, info_words, busy} !== {32'd0, 32'd0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d busy %b, expected 0/0/0 busy 0", data_words, cmd_words, info_words, busy);
    end
    checks++;
    if ({bus.data_read, bus.cmd_read, bus.info_read} !== 3'b000) begin
      errors++; $display("FAIL reset_reads: got %b%b%b, expected 000", bus.data_read, bus.cmd_read, bus.info_read);
    end
    checks++;
    if ({s_data_words, s_cmd_words, s_info_words, s_busy, sbus.nTx} !== {4'd0, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_small: got %0d/%0d/%0d busy %b nTx %b", s_data_words, s_cmd_words, s_info_words, s_busy, sbus.nTx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_word();
    logic [7:0] exp_d;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if ({rd_i, rd_c, rd_d} !== ((t >= 3) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL first_read t=%0d: got i/c/d %b%b%b", t, rd_i, rd_c, rd_d);
      end
      exp_d = 8'hA0 + 8'(t - 3);
      checks++;
      if (t <= 2) begin
        if (bus.nTx !== 1'b1) begin
          errors++; $display("FAIL first_idle t=%0d: nTx got %b expected 1", t, bus.nTx);
        end
      end else if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd2, exp_d}) begin
        errors++; $display("FAIL first_byte t=%0d: nTx/TC/D got %b/%0d/%h expected 0/2/%h", t, bus.nTx, bus.TC, bus.D, exp_d);
      end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_d;
    logic [2:0] exp_tc;
    logic [2:0] exp_rd;
    int c;
    for (int t = 7; t <= 51; t++) begin
      tick();
      c = t - 1;
      if (c <= 33)      exp_rd = 3'b100;
      else if (c <= 49) exp_rd = 3'b001;
      else              exp_rd = 3'b100;
      checks++;
      if ({rd_i, rd_c, rd_d} !== exp_rd) begin
        errors++; $display("FAIL starve_read t=%0d: got i/c/d %b%b%b expected %b", t, rd_i, rd_c, rd_d, exp_rd);
      end
      if (t <= 34)      begin exp_tc = 3'd2; exp_d = 8'hA0 + 8'(t - 3); end
      else if (t <= 50) begin exp_tc = 3'd0; exp_d = 8'(t - 35); end
      else              begin exp_tc = 3'd2; exp_d = 8'hC0; end
      checks++;
      if ({bus.nTx, bus.TC, bus.D} !== {1'b0, exp_tc, exp_d}) begin
        errors++; $display("FAIL starve_byte t=%0d: nTx/TC/D got %b/%0d/%h expected 0/%0d/%h", t, bus.nTx, bus.TC, bus.D, exp_tc, exp_d);
      end
      if (t == 50) begin
        checks++;
        if ({info_words, data_words, cmd_words} !== {32'd8, 32'd1, 32'd0}) begin
          errors++; $display("FAIL starve_counts: info/data/cmd got %0d/%0d/%0d expected 8/1/0", info_words, data_words, cmd_words);
        end
      end
    end
  endtask

  task automatic test_cmd_stall();
    set_valid(1'b0, 1'b1, 1'b0);
    bus.nTF = 8'hFF;
    apply_reset();
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 1) bus.nTF = 8'hFD;
      if (t == 3) bus.info_valid = 1'b1;
      if (t == 4) bus.nTF = 8'hFF;
      checks++;
      case (t)
        3: if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd1, 8'hC0}) begin
             errors++; $display("FAIL stall_b0: nTx/TC/D got %b/%0d/%h expected 0/1/c0", bus.nTx, bus.TC, bus.D);
           end
        4: if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd1, 8'hC1}) begin
             errors++; $display("FAIL stall_b1: nTx/TC/D got %b/%0d/%h expected 0/1/c1", bus.nTx, bus.TC, bus.D);
           end
        5, 6: if ({bus.nTx, bus.TC, bus.D, busy, rd_i} !== {1'b1, 3'd1, 8'hC1, 1'b1, 1'b0}) begin
             errors++; $display("FAIL stall_gap t=%0d: nTx/TC/D/busy/info_read got %b/%0d/%h/%b/%b expected 1/1/c1/1/0", t, bus.nTx, bus.TC, bus.D, busy, rd_i);
           end
        7: if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd1, 8'hC2}) begin
             errors++; $display("FAIL stall_b2: nTx/TC/D got %b/%0d/%h expected 0/1/c2", bus.nTx, bus.TC, bus.D);
           end
        8: if ({bus.nTx, bus.TC, bus.D, cmd_words, busy} !== {1'b0, 3'd1, 8'hC3, 32'd1, 1'b0}) begin
             errors++; $display("FAIL stall_b3: nTx/TC/D/cmd_words/busy got %b/%0d/%h/%0d/%b expected 0/1/c3/1/0", bus.nTx, bus.TC, bus.D, cmd_words, busy);
           end
        9: if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd2, 8'hA0}) begin
             errors++; $display("FAIL stall_info: nTx/TC/D got %b/%0d/%h expected 0/2/a0", bus.nTx, bus.TC, bus.D);
           end
        default: if (bus.nTx !== 1'b1) begin
             errors++; $display("FAIL stall_idle t=%0d: nTx got %b expected 1", t, bus.nTx);
           end
      endcase
    end
  endtask

  task automatic test_stats_clr();
    set_valid(1'b1, 1'b0, 1'b0);
    bus.nTF = 8'hFF;
    apply_reset();
    for (int t = 1; t <= 66; t++) begin
      tick();
      if (t == 49) stats_clr = 1'b1;
      if (t == 50) stats_clr = 1'b0;
      if (t == 34 || t == 49) begin
        checks++;
        if (data_words !== 32'd2) begin
          errors++; $display("FAIL clr_before t=%0d: data_words got %0d expected 2", t, data_words);
        end
      end
      if (t == 50 || t == 65) begin
        checks++;
        if (data_words !== 32'd0) begin
          errors++; $display("FAIL clr_wins t=%0d: data_words got %0d expected 0", t, data_words);
        end
      end
      if (t == 66) begin
        checks++;
        if ({data_words, bus.TC, bus.D} !== {32'd1, 3'd0, 8'd63}) begin
          errors++; $display("FAIL clr_after: data_words/TC/D got %0d/%0d/%h expected 1/0/3f", data_words, bus.TC, bus.D);
        end
      end
    end
  endtask

  task automatic test_reset_midword();
    set_valid(1'b1, 1'b0, 1'b0);
    bus.nTF = 8'hFF;
    apply_reset();
    repeat (7) tick();
    checks++;
    if ({bus.nTx, bus.D, busy} !== {1'b0, 8'd4, 1'b1}) begin
      errors++; $display("FAIL midword_pre: nTx/D/busy got %b/%h/%b expected 0/04/1", bus.nTx, bus.D, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.nTx, bus.TC, bus.D, busy, bus.data_read} !== {1'b1, 3'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midword_abort: nTx/TC/D/busy/read got %b/%0d/%h/%b/%b expected 1/0/00/0/0", bus.nTx, bus.TC, bus.D, busy, bus.data_read);
    end
    @(posedge eth_clk);
    #1;
    rst_n = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t <= 2) begin
        checks++;
        if (bus.nTx !== 1'b1) begin
          errors++; $display("FAIL midword_refill t=%0d: nTx got %b expected 1", t, bus.nTx);
        end
      end
      if (t == 3) begin
        checks++;
        if ({bus.nTx, bus.TC, bus.D} !== {1'b0, 3'd0, 8'd5}) begin
          errors++; $display("FAIL midword_restart: nTx/TC/D got %b/%0d/%h expected 0/0/05", bus.nTx, bus.TC, bus.D);
        end
      end
      if (t == 17 || t == 18) begin
        checks++;
        if (data_words !== ((t == 18) ? 32'd1 : 32'd0)) begin
          errors++; $display("FAIL midword_count t=%0d: data_words got %0d expected %0d", t, data_words, (t == 18) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    set_valid(1'b0, 1'b0, 1'b0);
    sbus.data_valid = 1'b1;
    apply_reset();
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 3) begin
        checks++;
        if ({sbus.nTx, sbus.TC, sbus.D, s_data_words} !== {1'b0, 3'd0, 8'h55, 4'd1}) begin
          errors++; $display("FAIL wrap_first: nTx/TC/D/words got %b/%0d/%h/%0d expected 0/0/55/1", sbus.nTx, sbus.TC, sbus.D, s_data_words);
        end
      end
      if (t == 17) begin
        checks++;
        if (s_data_words !== 4'd15) begin
          errors++; $display("FAIL wrap_15: data_words got %0d expected 15", s_data_words);
        end
      end
      if (t == 18) begin
        checks++;
        if (s_data_words !== 4'd0) begin
          errors++; $display("FAIL wrap_16: data_words got %0d expected 0", s_data_words);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_starvation();
    test_cmd_stall();
    test_stats_clr();
    test_reset_midword();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
